// File: rtl/id_ex_operand_latch_pkg.sv
// cpu_pkg: shared forward codes, pipeline state encoding and datapath widths
package cpu_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int REG_NUM_WIDTH = 4;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_R0 = 2'b10;
  localparam logic [1:0] FWD_RESERVED = 2'b11;
  typedef enum logic {
    ST_RUN,
    ST_LOAD_WAIT
  } state_t;
endpackage

// File: rtl/id_ex_operand_latch_operand_mux.sv
// operand_mux: forward select between register file, ALU result and R0 result
module operand_mux
  import cpu_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] rf_data,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] r0_result,
  output logic [W-1:0] y
);
  // reserved code falls back to register-file data
  always_comb y = sel == FWD_EX ? alu_result : sel == FWD_R0 ? r0_result : rf_data;
endmodule

// File: rtl/id_ex_operand_latch.sv
// id_ex_operand_latch: ID/EX register with forward muxing and load-use stall/bubble handling
module id_ex_operand_latch
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_NUM_WIDTH = cpu_pkg::REG_NUM_WIDTH,
  parameter int REG_FORWARD_WIDTH = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic                         id_is_load,
  input  logic                         id_write_reg,
  input  logic [REG_NUM_WIDTH-1:0]     rn_1,
  input  logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
  input  logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
  input  logic [DATA_WIDTH-1:0]        rf_data_1,
  input  logic [DATA_WIDTH-1:0]        rf_data_2,
  input  logic [DATA_WIDTH-1:0]        alu_result,
  input  logic [DATA_WIDTH-1:0]        r0_result,
  input  logic                         mem_ready,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic [DATA_WIDTH-1:0]        op_a,
  output logic [DATA_WIDTH-1:0]        op_b,
  output logic [REG_NUM_WIDTH-1:0]     ex_rn1,
  output logic                         ex_valid,
  output logic                         ex_is_load,
  output logic                         ex_write_reg,
  output logic                         stall_id,
  output logic                         load_timeout
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic need_a, need_b, hazard, timeout, capture, load_ex;
  logic [DATA_WIDTH-1:0] mux_a, mux_b;

  operand_mux #(.W(DATA_WIDTH)) u_mux_a (
    .sel(reg_forward_1), .rf_data(rf_data_1), .alu_result(alu_result), .r0_result(r0_result), .y(mux_a)
  );
  operand_mux #(.W(DATA_WIDTH)) u_mux_b (
    .sel(reg_forward_2), .rf_data(rf_data_2), .alu_result(alu_result), .r0_result(r0_result), .y(mux_b)
  );

  assign hazard = state == ST_RUN && id_valid && ex_valid && ex_is_load && ex_write_reg &&
                  (reg_forward_1 == FWD_EX || reg_forward_2 == FWD_EX);
  assign timeout = state == ST_LOAD_WAIT && !mem_ready && wait_cnt == CW'(MAX_WAIT);
  assign capture = state == ST_LOAD_WAIT && (mem_ready || timeout);
  assign load_ex = !flush && ((state == ST_RUN && !hazard && id_valid) || capture);

  // state register
  always_ff @(posedge clk) state <= !rst ? ST_RUN : state_nx;

  // next state: flush wins, a hazard enters the wait, a capture leaves it
  always_comb state_nx = flush ? ST_RUN : hazard ? ST_LOAD_WAIT : capture ? ST_RUN : state;

  // stall ID while a hazard is detected or the load data has not yet arrived
  always_comb stall_id = rst && !flush && (hazard || (state == ST_LOAD_WAIT && !capture));

  // EX registers, need flags, wait counter and sticky timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
      ex_rn1 <= '0;
      ex_valid <= 1'b0;
      ex_is_load <= 1'b0;
      ex_write_reg <= 1'b0;
      need_a <= 1'b0;
      need_b <= 1'b0;
      wait_cnt <= '0;
      load_timeout <= 1'b0;
    end else begin
      if (load_ex) begin
        op_a <= capture && need_a ? mem_data : mux_a;
        op_b <= capture && need_b ? mem_data : mux_b;
        ex_rn1 <= rn_1;
        ex_valid <= 1'b1;
        ex_is_load <= id_is_load;
        ex_write_reg <= id_write_reg;
      end else if (flush || state == ST_RUN) begin
        ex_valid <= 1'b0;
        ex_is_load <= 1'b0;
        ex_write_reg <= 1'b0;
      end
      need_a <= flush || capture ? 1'b0 : hazard ? reg_forward_1 == FWD_EX : need_a;
      need_b <= flush || capture ? 1'b0 : hazard ? reg_forward_2 == FWD_EX : need_b;
      wait_cnt <= flush || hazard || capture ? '0 : state == ST_LOAD_WAIT ? wait_cnt + CW'(1) : wait_cnt;
      load_timeout <= load_timeout || (timeout && !flush);
    end
  end
endmodule

// File: tb/tb_id_ex_operand_latch.sv
// tb_id_ex_operand_latch: scoreboard bench with directed and random stimulus against a reference model
module tb_id_ex_operand_latch;
  localparam int MAX_WAIT = 3;

  typedef struct packed {
    logic rst, flush, id_valid, is_load, wr;
    logic [3:0] rn;
    logic [1:0] f1, f2;
    logic [15:0] rf1, rf2, alu, r0;
    logic mem_ready;
    logic [15:0] mem_data;
  } stim_t;

  typedef struct packed {
    logic stall;
    logic [15:0] op_a, op_b;
    logic [3:0] rn;
    logic v, l, w, to;
  } exp_t;

  logic clk = 0, rst = 0, flush = 0, id_valid = 0, id_is_load = 0, id_write_reg = 0, mem_ready = 0;
  logic [3:0] rn_1 = 0, ex_rn1;
  logic [1:0] reg_forward_1 = 0, reg_forward_2 = 0;
  logic [15:0] rf_data_1 = 0, rf_data_2 = 0, alu_result = 0, r0_result = 0, mem_data = 0, op_a, op_b;
  logic ex_valid, ex_is_load, ex_write_reg, stall_id, load_timeout;

  int checks = 0, errors = 0;
  exp_t q[$];
  stim_t last;

  logic [15:0] m_op_a = 0, m_op_b = 0;
  logic [3:0] m_rn = 0;
  logic m_v = 0, m_l = 0, m_w = 0, m_to = 0, m_wait = 0, m_na = 0, m_nb = 0;
  int m_waited = 0;

  id_ex_operand_latch #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_is_load(id_is_load),
    .id_write_reg(id_write_reg), .rn_1(rn_1), .reg_forward_1(reg_forward_1), .reg_forward_2(reg_forward_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .alu_result(alu_result), .r0_result(r0_result),
    .mem_ready(mem_ready), .mem_data(mem_data), .op_a(op_a), .op_b(op_b), .ex_rn1(ex_rn1),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_write_reg(ex_write_reg),
    .stall_id(stall_id), .load_timeout(load_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fsel(input logic [1:0] sel, input logic [15:0] rf, alu, r0);
    return sel == 2'b01 ? alu : sel == 2'b10 ? r0 : rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic take(input stim_t s, input logic na, input logic nb);
    m_op_a = na ? s.mem_data : fsel(s.f1, s.rf1, s.alu, s.r0);
    m_op_b = nb ? s.mem_data : fsel(s.f2, s.rf2, s.alu, s.r0);
    m_rn = s.rn;
    m_v = 1;
    m_l = s.is_load;
    m_w = s.wr;
  endtask

  task automatic model(input stim_t s, output exp_t e);
    e.stall = 0;
    if (!s.rst) begin
      m_op_a = 0; m_op_b = 0; m_rn = 0; m_v = 0; m_l = 0; m_w = 0; m_to = 0;
      m_wait = 0; m_na = 0; m_nb = 0; m_waited = 0;
    end else if (s.flush) begin
      m_v = 0; m_l = 0; m_w = 0; m_wait = 0; m_na = 0; m_nb = 0; m_waited = 0;
    end else if (!m_wait) begin
      if (s.id_valid && m_v && m_l && m_w && (s.f1 == 2'b01 || s.f2 == 2'b01)) begin
        e.stall = 1;
        m_na = s.f1 == 2'b01;
        m_nb = s.f2 == 2'b01;
        m_v = 0; m_l = 0; m_w = 0;
        m_wait = 1;
        m_waited = 0;
      end else if (s.id_valid) take(s, 1'b0, 1'b0);
      else begin
        m_v = 0; m_l = 0; m_w = 0;
      end
    end else if (s.mem_ready || m_waited == MAX_WAIT) begin
      if (!s.mem_ready) m_to = 1;
      take(s, m_na, m_nb);
      m_wait = 0; m_na = 0; m_nb = 0;
    end else begin
      e.stall = 1;
      m_waited++;
    end
    e.op_a = m_op_a; e.op_b = m_op_b; e.rn = m_rn;
    e.v = m_v; e.l = m_l; e.w = m_w; e.to = m_to;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; flush = s.flush; id_valid = s.id_valid; id_is_load = s.is_load; id_write_reg = s.wr;
    rn_1 = s.rn; reg_forward_1 = s.f1; reg_forward_2 = s.f2; rf_data_1 = s.rf1; rf_data_2 = s.rf2;
    alu_result = s.alu; r0_result = s.r0; mem_ready = s.mem_ready; mem_data = s.mem_data;
    model(s, e);
    q.push_back(e);
    last = s;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = $urandom_range(99) != 0;
    s.flush = $urandom_range(19) == 0;
    s.id_valid = $urandom_range(9) < 8;
    s.is_load = 1'($urandom_range(1));
    s.wr = $urandom_range(3) != 0;
    s.rn = 4'($urandom);
    s.f1 = 2'($urandom_range(3));
    s.f2 = 2'($urandom_range(3));
    s.rf1 = 16'($urandom); s.rf2 = 16'($urandom);
    s.alu = 16'($urandom); s.r0 = 16'($urandom);
    s.mem_ready = $urandom_range(2) == 0;
    s.mem_data = 16'($urandom);
    if (m_wait) begin
      s.id_valid = last.id_valid; s.is_load = last.is_load; s.wr = last.wr; s.rn = last.rn;
      s.f1 = last.f1; s.f2 = last.f2; s.rf1 = last.rf1; s.rf2 = last.rf2;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_id", 32'(stall_id), 32'(e.stall));
        @(posedge clk);
        #1;
        chk("op_a", 32'(op_a), 32'(e.op_a));
        chk("op_b", 32'(op_b), 32'(e.op_b));
        chk("ex_rn1", 32'(ex_rn1), 32'(e.rn));
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("ex_is_load", 32'(ex_is_load), 32'(e.l));
        chk("ex_write_reg", 32'(ex_write_reg), 32'(e.w));
        chk("load_timeout", 32'(load_timeout), 32'(e.to));
      end
    end
  end

  initial begin
    stim_t s, ld, use_b, use_a;
    s = idle(); s.rst = 0; s.id_valid = 1; s.is_load = 1; s.wr = 1; s.rn = 4'hF; s.f1 = 2'b01;
    s.rf1 = 16'hFFFF; s.alu = 16'h7777; s.mem_ready = 1; s.mem_data = 16'h5555;
    apply(s); apply(s);
    apply(idle());
    s = idle(); s.id_valid = 1; s.rn = 1; s.f1 = 2'b01; s.alu = 16'h1234; s.f2 = 2'b10; s.r0 = 16'hBEEF;
    apply(s);
    s.f1 = 2'b11; s.f2 = 2'b11; s.rf1 = 16'h00AA; s.rf2 = 16'h00AA; apply(s);
    ld = idle(); ld.id_valid = 1; ld.is_load = 1; ld.wr = 1; ld.rn = 3;
    use_b = idle(); use_b.id_valid = 1; use_b.wr = 1; use_b.rn = 4; use_b.f2 = 2'b01; use_b.rf1 = 16'h0005;
    apply(ld); apply(use_b); apply(use_b);
    s = use_b; s.mem_ready = 1; s.mem_data = 16'hC0DE; apply(s);
    use_a = idle(); use_a.id_valid = 1; use_a.rn = 6; use_a.f1 = 2'b01; use_a.rf2 = 16'h0042;
    use_a.mem_data = 16'hDEAD;
    apply(ld);
    for (int i = 0; i < 5; i++) apply(use_a);
    apply(idle()); apply(idle());
    apply(ld); apply(use_b); apply(use_b);
    s = use_b; s.flush = 1; s.mem_ready = 1; apply(s);
    s = idle(); s.mem_ready = 1; s.mem_data = 16'h9999; apply(s); apply(s);
    s = idle(); s.id_valid = 1; s.rn = 9; s.rf1 = 16'h1111; s.rf2 = 16'h2222; apply(s);
    s.id_valid = 0; s.rf1 = 16'h3333; s.rf2 = 16'h4444; s.rn = 2; apply(s);
    s = idle(); s.rst = 0; apply(s);
    for (int i = 0; i < 600; i++) apply(rnd());
    apply(idle());
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
